signal_capture: RTL and testbench
=================================

# signal_capture

Synthetic ADC front-end for the signal-separation datapath. Running from the 50 MHz system clock, it produces a two-tone mixed test signal as unsigned 12-bit samples at a 1.024 MHz sample rate, standing in for the real ADC capture. It counts samples into 1024-point frames and pulses `fft_flag` at the end of each frame so the downstream FFT can start.

## Interface
- `FS_INC`, 32'd87960930: sample-strobe phase increment per clock (round(1.024e6/50e6·2^32)).
- `F1_WORD`, 16'd640: tone-1 phase increment per sample (10 kHz = word·fs/2^16).
- `F2_WORD`, 16'd1280: tone-2 phase increment per sample (20 kHz).
- `N_SAMPLES`, 1024: samples per frame (power of two, ≤ 65536).
- `sys_clk  input  1`: 50 MHz system clock; all logic on rising edge.
- `sys_rst  input  1`: reset, synchronous, active-high.
- `mix_signal  output  12`: current mixed sample, unsigned, offset-binary (midscale 2048).
- `fft_flag  output  1`: one-clock pulse when the last sample of a frame is presented.

## Operation
- Sample-rate generator: 32-bit accumulator `acc <= acc + FS_INC` every clock; carry-out of the add is registered as `samp_en`. Strobe intervals are 48 or 49 clocks, averaging 48.828.
- Sine ROM: 256 entries, signed 11-bit, `sin_tab[k] = round(1023·sin(2πk/256))`. Range is −1023..+1023.
- Tone phases: `p1`, `p2` are 16-bit and wrap modulo 2^16. On `samp_en`: `p1 <= p1+F1_WORD` and `p2 <= p2+F2_WORD`.
- Mixer: on `samp_en`, `mix_signal <= 2048 + sin_tab[p1[15:8]] + sin_tab[p2[15:8]]`, using the pre-increment phases. The sum is computed at 13 bits signed.
  - Result range is 2..4094, so no saturation is needed.
  - The output is held between strobes.
- Frame counter: `cnt` runs 0..N_SAMPLES−1 and increments on `samp_en`.
  - On `samp_en` with `cnt == N_SAMPLES−1`: `cnt <= 0` and `fft_flag <= 1`.
  - On every other clock, `fft_flag <= 0`.
- Frames are free-running and back-to-back. Frame k+1 starts on the strobe after the flag, with no gap and no dependence on the FFT.
- Reset (synchronous, any time, including mid-frame): `acc`, `samp_en`, `p1`, `p2`, `cnt` = 0; `mix_signal` = 12'd2048; `fft_flag` = 0. The next frame starts fully fresh.

## Timing
- Reset values: `mix_signal` = 2048, `fft_flag` = 0.
- First carry: on the 49th clock edge after reset deasserts (48·FS_INC < 2^32 ≤ 49·FS_INC). `samp_en` is high during the following cycle.
- `mix_signal` updates on the edge that samples `samp_en` = 1, so update latency is 1 clock from the carry. The first post-reset sample is 2048, because both phases are 0.
- `fft_flag` rises on the same edge as the N_SAMPLES-th `mix_signal` update and is high for exactly one clock.
- Frame period: N_SAMPLES·2^32/FS_INC clocks, which is 50000 (±1) clocks for 1024 samples, i.e. 1 ms.
- Phase wrap: `p1` wraps after 102.4 samples, so there is no period alignment with the frame. Wrap-around is silent.
- `samp_en` never coincides with itself on consecutive clocks, since FS_INC < 2^31.

## Test plan
- Reset hold: `sys_rst` = 1 for 5 clocks -> `mix_signal` == 2048 and `fft_flag` == 0 throughout; release -> first `mix_signal` update occurs 50 clocks after release, value 2048.
- Strobe cadence: count clocks between `mix_signal` updates over 1024 samples -> every interval is 48 or 49, total 50000±1.
- Waveform values: check samples 1–4 of frame 0 against a model computed from sin_tab and the F1/F2 phase schedule. Sample 1: p1 = 640, p2 = 1280 -> index 2 and 5; expected 2048 + sin_tab[2] + sin_tab[5] = 2048 + 50 + 125 = 2223. Samples 2–4 follow the same schedule and must match the model exactly.
- Frame flag: run 3 frames -> `fft_flag` is a 1-clock pulse coinciding with the 1024th, 2048th and 3072nd update; pulse spacing is 50000±1 clocks.
- Range: run 10 frames -> `mix_signal` stays within 2..4094, and min/max fall within 1 LSB of 2048 ± (peak of the two-tone sum).
- Mid-frame reset: assert `sys_rst` one clock at sample 500 -> outputs return to 2048/0. The next `fft_flag` comes 1024 samples after release, not at the old frame boundary.

Source files
------------

// File: rtl/signal_capture.sv
// signal_capture
// Synthetic ADC front-end. It generates a two-tone test signal as unsigned
// 12-bit offset-binary samples at about 1.024 MHz from the 50 MHz system
// clock, and it groups the samples into frames of N_SAMPLES for the FFT.
//
// Ports:
//   sys_clk     in   1   system clock; every register updates on the rising edge
//   sys_rst     in   1   synchronous active-high reset
//   mix_signal  out  12  current mixed sample, held between sample strobes
//   fft_flag    out  1   one-clock pulse when the last sample of a frame appears
module signal_capture #(
    parameter logic [31:0] FS_INC    = 32'd87960930,
    parameter logic [15:0] F1_WORD   = 16'd640,
    parameter logic [15:0] F2_WORD   = 16'd1280,
    parameter int          N_SAMPLES = 1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    output logic [11:0] mix_signal,
    output logic        fft_flag
);

    localparam int CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);

    logic [31:0]       acc;
    logic              samp_en;
    logic [15:0]       p1;
    logic [15:0]       p2;
    logic [CNT_W-1:0]  cnt;
    logic [32:0]       acc_sum;
    logic signed [10:0] tone1;
    logic signed [10:0] tone2;
    logic signed [12:0] mix_sum;

    // First quadrant of round(1023*sin(2*pi*j/256)) for j = 0..64. The other
    // three quadrants are mirror images, so the full 256-entry table is never
    // stored.
    function automatic logic [9:0] quarter_sin(input logic [6:0] j);
        logic [9:0] q;
        case (j)
            7'd0:  q = 10'd0;    7'd1:  q = 10'd25;   7'd2:  q = 10'd50;
            7'd3:  q = 10'd75;   7'd4:  q = 10'd100;  7'd5:  q = 10'd125;
            7'd6:  q = 10'd150;  7'd7:  q = 10'd175;  7'd8:  q = 10'd200;
            7'd9:  q = 10'd224;  7'd10: q = 10'd249;  7'd11: q = 10'd273;
            7'd12: q = 10'd297;  7'd13: q = 10'd321;  7'd14: q = 10'd345;
            7'd15: q = 10'd368;  7'd16: q = 10'd391;  7'd17: q = 10'd415;
            7'd18: q = 10'd437;  7'd19: q = 10'd460;  7'd20: q = 10'd482;
            7'd21: q = 10'd504;  7'd22: q = 10'd526;  7'd23: q = 10'd547;
            7'd24: q = 10'd568;  7'd25: q = 10'd589;  7'd26: q = 10'd609;
            7'd27: q = 10'd629;  7'd28: q = 10'd649;  7'd29: q = 10'd668;
            7'd30: q = 10'd687;  7'd31: q = 10'd705;  7'd32: q = 10'd723;
            7'd33: q = 10'd741;  7'd34: q = 10'd758;  7'd35: q = 10'd775;
            7'd36: q = 10'd791;  7'd37: q = 10'd806;  7'd38: q = 10'd822;
            7'd39: q = 10'd836;  7'd40: q = 10'd851;  7'd41: q = 10'd864;
            7'd42: q = 10'd877;  7'd43: q = 10'd890;  7'd44: q = 10'd902;
            7'd45: q = 10'd914;  7'd46: q = 10'd925;  7'd47: q = 10'd935;
            7'd48: q = 10'd945;  7'd49: q = 10'd954;  7'd50: q = 10'd963;
            7'd51: q = 10'd971;  7'd52: q = 10'd979;  7'd53: q = 10'd986;
            7'd54: q = 10'd992;  7'd55: q = 10'd998;  7'd56: q = 10'd1003;
            7'd57: q = 10'd1008; 7'd58: q = 10'd1012; 7'd59: q = 10'd1015;
            7'd60: q = 10'd1018; 7'd61: q = 10'd1020; 7'd62: q = 10'd1022;
            7'd63: q = 10'd1023; 7'd64: q = 10'd1023;
            default: q = 10'd0;
        endcase
        return q;
    endfunction

    // Bit 6 of the index selects a falling quadrant, which reads the quarter
    // table backwards (index 64 - m). Bit 7 selects the negative half-wave.
    function automatic logic signed [10:0] sin_lookup(input logic [7:0] idx);
        logic [6:0]         j;
        logic signed [10:0] s;
        j = idx[6] ? (7'd64 - {1'b0, idx[5:0]}) : {1'b0, idx[5:0]};
        s = $signed({1'b0, quarter_sin(j)});
        return idx[7] ? -s : s;
    endfunction

    // The carry out of the phase accumulator is the sample strobe. The mixer
    // reads the phases before they advance, so the first sample after reset
    // is exactly midscale.
    always_comb begin
        acc_sum = {1'b0, acc} + {1'b0, FS_INC};
        tone1   = sin_lookup(p1[15:8]);
        tone2   = sin_lookup(p2[15:8]);
        mix_sum = 13'sd2048 + 13'(tone1) + 13'(tone2);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            acc        <= '0;
            samp_en    <= 1'b0;
            p1         <= '0;
            p2         <= '0;
            cnt        <= '0;
            mix_signal <= 12'd2048;
            fft_flag   <= 1'b0;
        end else begin
            acc      <= acc_sum[31:0];
            samp_en  <= acc_sum[32];
            fft_flag <= 1'b0;
            if (samp_en) begin
                p1         <= p1 + F1_WORD;
                p2         <= p2 + F2_WORD;
                // The two-tone sum stays within 2..4094, so the low 12 bits
                // hold the whole value and no clamping is required.
                mix_signal <= mix_sum[11:0];
                if (cnt == CNT_LAST) begin
                    cnt      <= '0;
                    fft_flag <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_signal_capture.sv
// tb_signal_capture
// Directed bench for signal_capture. The frame length is shortened to 64
// samples so that several frames fit in a short run. Every other parameter
// keeps its real value. Expected sample values come from a sine table that
// the bench computes with real arithmetic. Expected update times come from
// the closed form floor((e-1)*FS_INC/2^32), which gives the number of samples
// presented by clock edge e after reset is released.
`timescale 1ns/1ps
module tb_signal_capture;

    localparam logic [31:0] FS = 32'd87960930;
    localparam int          N  = 64;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [11:0] mix_signal;
    logic        fft_flag;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint edge_cnt = 0;
    int     sin_tab[256];

    signal_capture #(
        .FS_INC   (FS),
        .F1_WORD  (16'd640),
        .F2_WORD  (16'd1280),
        .N_SAMPLES(N)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .mix_signal(mix_signal),
        .fft_flag  (fft_flag)
    );

    always #10 sys_clk = ~sys_clk;

    // Advance one rising edge and return at the following falling edge, where
    // outputs are sampled and inputs are driven.
    task automatic tick();
        @(posedge sys_clk);
        edge_cnt = edge_cnt + 1;
        @(negedge sys_clk);
    endtask

    task automatic apply_reset(input int cycles);
        sys_rst = 1'b1;
        repeat (cycles) tick();
        sys_rst  = 1'b0;
        edge_cnt = 0;
    endtask

    // Number of samples presented by edge e after release.
    function automatic longint n_upd(input longint e);
        if (e < 2) return 0;
        return ((e - 1) * longint'(FS)) >> 32;
    endfunction

    // Edge on which 0-based sample k appears.
    function automatic longint edge_of_sample(input longint k);
        longint num;
        num = (k + 1) * (longint'(1) << 32);
        return (num + longint'(FS) - 1) / longint'(FS) + 1;
    endfunction

    function automatic logic [11:0] sample_value(input longint k);
        int i1;
        int i2;
        i1 = int'(((k * 640) % 65536) / 256);
        i2 = int'(((k * 1280) % 65536) / 256);
        return 12'(2048 + sin_tab[i1] + sin_tab[i2]);
    endfunction

    task automatic test_reset();
        int bad;
        sys_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (mix_signal !== 12'd2048) begin
                n_fail++;
                $display("[TB] FAIL reset_mix cycle %0d: got %0d want 2048", i, mix_signal);
            end
            n_checks++;
            if (fft_flag !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_flag cycle %0d: got %b want 0", i, fft_flag);
            end
        end
        sys_rst  = 1'b0;
        edge_cnt = 0;
        bad = 0;
        while (edge_cnt < 50) begin
            tick();
            if (bad == 0 && (mix_signal !== 12'd2048 || fft_flag !== 1'b0)) begin
                bad = 1;
                $display("[TB] FAIL release_hold edge %0d: got mix %0d flag %b want 2048/0",
                         edge_cnt, mix_signal, fft_flag);
            end
        end
        n_checks++;
        if (bad != 0) n_fail++;
    endtask

    // Samples 1..4 after release, with hand-derived edges and values.
    task automatic test_first_samples();
        int          upd_edge[5];
        logic [11:0] upd_val[5];
        upd_edge = '{50, 99, 148, 197, 246};
        upd_val  = '{12'd2048, 12'd2223, 12'd2422, 12'd2591, 12'd2779};
        for (int i = 1; i < 5; i++) begin
            while (edge_cnt < longint'(upd_edge[i] - 1)) tick();
            n_checks++;
            if (mix_signal !== upd_val[i-1]) begin
                n_fail++;
                $display("[TB] FAIL held_sample%0d edge %0d: got %0d want %0d",
                         i - 1, edge_cnt, mix_signal, upd_val[i-1]);
            end
            tick();
            n_checks++;
            if (mix_signal !== upd_val[i]) begin
                n_fail++;
                $display("[TB] FAIL sample%0d edge %0d: got %0d want %0d",
                         i, edge_cnt, mix_signal, upd_val[i]);
            end
        end
    endtask

    // Every edge over two frames is compared against the timing model, so any
    // interval that is not 48/49 clocks shows up as a wrong value or flag.
    task automatic test_cadence();
        longint      last;
        longint      cnt_now;
        logic [11:0] exp_mix;
        logic        exp_flag;
        apply_reset(2);
        last = edge_of_sample(2 * N - 1) + 5;
        while (edge_cnt < last) begin
            tick();
            cnt_now  = n_upd(edge_cnt);
            exp_mix  = (cnt_now == 0) ? 12'd2048 : sample_value(cnt_now - 1);
            exp_flag = (cnt_now > 0) && (cnt_now != n_upd(edge_cnt - 1)) && (cnt_now % N == 0);
            n_checks++;
            if (mix_signal !== exp_mix || fft_flag !== exp_flag) begin
                n_fail++;
                $display("[TB] FAIL cadence edge %0d: got mix %0d flag %b want %0d/%b",
                         edge_cnt, mix_signal, fft_flag, exp_mix, exp_flag);
                break;
            end
        end
    endtask

    task automatic test_frame_flag();
        longint fe[3];
        longint budget;
        longint d;
        int     seen;
        int     wide;
        logic   prev;
        fe = '{-1, -1, -1};
        seen = 0;
        wide = 0;
        prev = 1'b0;
        apply_reset(2);
        budget = edge_of_sample(3 * N - 1) + 100;
        while (edge_cnt < budget) begin
            tick();
            if (fft_flag === 1'b1) begin
                if (prev === 1'b1) wide = 1;
                if (seen < 3) begin
                    fe[seen] = edge_cnt;
                    n_checks++;
                    if (mix_signal !== sample_value(longint'(N * (seen + 1) - 1))) begin
                        n_fail++;
                        $display("[TB] FAIL flag_sample frame %0d: got %0d want %0d", seen,
                                 mix_signal, sample_value(longint'(N * (seen + 1) - 1)));
                    end
                end
                seen++;
            end
            prev = fft_flag;
        end
        n_checks++;
        if (seen != 3) begin
            n_fail++;
            $display("[TB] FAIL flag_count: got %0d want 3", seen);
        end
        n_checks++;
        if (wide != 0) begin
            n_fail++;
            $display("[TB] FAIL flag_width: got multi-cycle pulse want 1 clock");
        end
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if (fe[j] != edge_of_sample(longint'(N * (j + 1) - 1))) begin
                n_fail++;
                $display("[TB] FAIL flag_edge frame %0d: got %0d want %0d", j, fe[j],
                         edge_of_sample(longint'(N * (j + 1) - 1)));
            end
        end
        for (int j = 1; j < 3; j++) begin
            d = fe[j] - fe[j-1];
            n_checks++;
            if (d < 3124 || d > 3126) begin
                n_fail++;
                $display("[TB] FAIL flag_spacing %0d: got %0d want 3124..3126", j, d);
            end
        end
    endtask

    task automatic test_range();
        int     mod_min;
        int     mod_max;
        int     obs_min;
        int     obs_max;
        int     v;
        int     oor;
        longint last;
        mod_min = 4096;
        mod_max = -1;
        for (int k = 0; k < 10 * N; k++) begin
            v = int'(sample_value(longint'(k)));
            if (v < mod_min) mod_min = v;
            if (v > mod_max) mod_max = v;
        end
        obs_min = 4096;
        obs_max = -1;
        oor = 0;
        apply_reset(2);
        last = edge_of_sample(10 * N - 1) + 2;
        while (edge_cnt < last) begin
            tick();
            v = int'(mix_signal);
            if (v < obs_min) obs_min = v;
            if (v > obs_max) obs_max = v;
            if (v < 2 || v > 4094 || $isunknown(mix_signal)) oor = 1;
        end
        n_checks++;
        if (oor != 0) begin
            n_fail++;
            $display("[TB] FAIL range_bounds: got out-of-range value want 2..4094");
        end
        n_checks++;
        if (obs_min != mod_min) begin
            n_fail++;
            $display("[TB] FAIL range_min: got %0d want %0d", obs_min, mod_min);
        end
        n_checks++;
        if (obs_max != mod_max) begin
            n_fail++;
            $display("[TB] FAIL range_max: got %0d want %0d", obs_max, mod_max);
        end
    endtask

    task automatic test_mid_frame_reset();
        longint target;
        longint budget;
        longint first_flag;
        apply_reset(2);
        target = edge_of_sample(32);
        while (edge_cnt < target) tick();
        n_checks++;
        if (mix_signal !== sample_value(32)) begin
            n_fail++;
            $display("[TB] FAIL mid_sample32: got %0d want %0d", mix_signal, sample_value(32));
        end
        sys_rst = 1'b1;
        tick();
        n_checks++;
        if (mix_signal !== 12'd2048 || fft_flag !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset: got mix %0d flag %b want 2048/0", mix_signal, fft_flag);
        end
        sys_rst  = 1'b0;
        edge_cnt = 0;
        first_flag = -1;
        budget = edge_of_sample(N - 1) + 100;
        while (edge_cnt < budget && first_flag < 0) begin
            tick();
            if (edge_cnt == 99) begin
                n_checks++;
                if (mix_signal !== 12'd2223) begin
                    n_fail++;
                    $display("[TB] FAIL mid_fresh_sample1: got %0d want 2223", mix_signal);
                end
            end
            if (fft_flag === 1'b1) first_flag = edge_cnt;
        end
        n_checks++;
        if (first_flag != edge_of_sample(N - 1)) begin
            n_fail++;
            $display("[TB] FAIL mid_next_flag: got edge %0d want %0d",
                     first_flag, edge_of_sample(N - 1));
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            real x;
            x = 1023.0 * $sin(2.0 * 3.141592653589793 * k / 256.0);
            sin_tab[k] = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
        end
        test_reset();
        test_first_samples();
        test_cadence();
        test_frame_flag();
        test_range();
        test_mid_frame_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
